// File: rtl/serial_parity_checker.sv
// Bit-serial frame receiver: DATA_BITS data bits LSB-first plus one parity bit, checked against ODD_PARITY.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] frame_data,
`ifdef PARITY_ERR_CNT_EN
  output logic [7:0]           err_count,
`endif
  output logic                 parity_err
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic ODD_L = (ODD_PARITY != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // A one-bit frame goes straight from its only data bit to the parity bit.
  localparam state_t FIRST_STATE = (DATA_BITS == 1) ? ST_PARITY : ST_DATA;

  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_next_s;
  logic [DATA_BITS-1:0] first_word_s;
  logic [CNT_W-1:0]     count_r;
  logic                 acc_r;
  logic                 perr_s;

  function automatic logic parity_mismatch(input logic acc, input logic p, input logic odd);
    return p ^ acc ^ odd;
  endfunction

  assign perr_s = parity_mismatch(acc_r, bit_in, ODD_L);

  // Shift register with the incoming bit written at the current count position.
  always_comb begin
    shift_next_s = shift_r;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (count_r == CNT_W'(i)) begin
        shift_next_s[i] = bit_in;
      end else begin
        shift_next_s[i] = shift_r[i];
      end
    end
  end

  // Fresh word holding only data bit 0, used when a sof bit opens a frame.
  always_comb begin
    first_word_s    = {DATA_BITS{1'b0}};
    first_word_s[0] = bit_in;
  end

  // Frame FSM with registered outputs; sof always restarts, aborting any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= {DATA_BITS{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      acc_r      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_data <= {DATA_BITS{1'b0}};
      parity_err <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      if (bit_valid && sof) begin
        shift_r <= first_word_s;
        acc_r   <= bit_in;
        count_r <= CNT_W'(1);
        state_r <= FIRST_STATE;
        busy    <= 1'b1;
      end else if (bit_valid) begin
        case (state_r)
          ST_DATA: begin
            shift_r <= shift_next_s;
            acc_r   <= acc_r ^ bit_in;
            count_r <= count_r + CNT_W'(1);
            if (count_r == LAST_DATA_IDX) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_PARITY: begin
            done       <= 1'b1;
            frame_data <= shift_r;
            parity_err <= perr_s;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
            count_r    <= {CNT_W{1'b0}};
            acc_r      <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
            if (perr_s && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end else begin
              err_count <= err_count;
            end
`endif
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Bit-serial frame receiver that takes the XOR-stage output stream and deserialises DATA_BITS data bits LSB-first, followed by one parity bit.
- Accumulates a running XOR parity over the data bits and compares it against the received parity bit.
- Sits directly downstream of the 1-bit XOR stage. Its bit_in is driven from that stage's y output.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 1..32.
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bit_in  input  1  serial data bit, sampled only when bit_valid=1
- bit_valid  input  1  qualifies bit_in for the current cycle
- sof  input  1  start of frame; qualifies bit_in as data bit 0 (only meaningful when bit_valid=1)
- busy  output  1  high while a frame is in progress (state DATA or PARITY)
- done  output  1  single-cycle pulse when a frame completes
- frame_data  output  DATA_BITS  received data word, bit 0 = first bit received
- parity_err  output  1  1 when the received parity bit mismatches the expected parity

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, shift register=0, bit count=0, parity accumulator=0, busy=0, done=0, frame_data=0, parity_err=0.
- A bit is accepted only on a rising edge with bit_valid=1. Cycles with bit_valid=0 hold all state (stall); there is no timeout.
- States are IDLE, DATA, PARITY.
- IDLE:
  - An accepted bit with sof=1 becomes data bit 0: shift register bit 0 = bit_in, acc = bit_in, count = 1.
  - Next state is PARITY if DATA_BITS==1, otherwise DATA.
  - An accepted bit with sof=0 is discarded.
- DATA:
  - Each accepted bit is written to shift-register position [count], then acc ^= bit_in and count++.
  - When count reaches DATA_BITS, next state is PARITY.
- PARITY:
  - The accepted bit is the received parity bit p.
  - expected = acc ^ ODD_PARITY; err = (p != expected).
  - Next state is IDLE.
- Completion: on the cycle after the parity bit is accepted, done=1 for exactly one cycle. In that same cycle frame_data and parity_err are updated, and they hold until the next done.
- busy is registered: 1 from the cycle after the sof bit is accepted until the cycle in which done=1. busy=0 while done=1.
- sof=1 with bit_valid=1 while in DATA or PARITY aborts the current frame:
  - No done pulse; frame_data and parity_err are unchanged.
  - The abort bit is taken as data bit 0 of a new frame (count=1, acc=bit_in).
- An accepted sof bit in the same cycle that done=1 is legal and starts a new frame (back-to-back frames).
- sof=1 with bit_valid=0 is ignored.
- Reset asserted mid-frame discards the partial frame immediately. No done is generated.
- Counter width is clog2(DATA_BITS+1). The accumulator is 1 bit.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: adds output err_count (8 bits), reset to 0.
  - Increments by 1 on each done pulse with parity_err=1.
  - Saturates at 255.
  - Aborted frames do not count.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then send sof+bits 1,0,1,0,0,1,0,1 (0xA5) followed by parity 0, with ODD_PARITY=0 -> one cycle after the parity bit: done=1, frame_data=0xA5, parity_err=0; busy=0 afterwards.
- Same frame with parity bit 1 -> done=1, frame_data=0xA5, parity_err=1. With ODD_PARITY=1 and parity bit 1 -> parity_err=0.
- Send 0x3C with random bit_valid gaps of 0-5 cycles between bits -> frame_data=0x3C, done pulses exactly once, state holds through all gaps.
- Send sof + 4 bits of 0xFF, then sof with the full frame 0x01 plus parity 1 -> exactly one done, frame_data=0x01, parity_err=0.
- Assert rst_n=0 after 5 bits of a frame, then release -> all outputs 0, no done pulse. Next full frame 0x80 with parity 1 -> done=1, frame_data=0x80, parity_err=0.
- With PARITY_ERR_CNT_EN defined: 3 bad-parity frames -> err_count=3. Then 300 bad frames -> err_count=255 (saturated). Good frames and aborted frames leave err_count unchanged.
